// File: rtl/rf_writeback_ctrl.sv
// Register-file write-side controller: merges the ALU and load writeback paths
// into one RF write port and keeps a per-register pending-write scoreboard.
module rf_writeback_ctrl #(
  parameter int DSIZE  = 16,
  parameter int RSIZE  = 4,
  parameter int QDEPTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  alu_valid,
  input  logic [RSIZE-1:0]      alu_addr,
  input  logic [DSIZE-1:0]      alu_data,
  input  logic                  ld_valid,
  input  logic [RSIZE-1:0]      ld_addr,
  input  logic [DSIZE-1:0]      ld_data,
  input  logic                  iss_valid,
  input  logic [RSIZE-1:0]      iss_addr,
  output logic                  Wen,
  output logic [RSIZE-1:0]      WAddr,
  output logic [DSIZE-1:0]      WData,
  output logic [2**RSIZE-1:0]   busy,
  output logic                  wb_stall,
  output logic                  overflow
);

  localparam int NREG = 2**RSIZE;
  localparam int PW   = $clog2(QDEPTH);
  localparam int CW   = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [RSIZE-1:0] addr;
    logic [DSIZE-1:0] data;
  } wb_t;

  wb_t           q_mem [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [1:0]    sb [1:NREG-1];

  wb_t  ld_in, alu_in, head, new0, new1, out_ent, push_a, push_b;
  logic ld_ok, alu_ok, new0_v, new1_v, out_v, pop;
  logic push_a_v, push_b_v, acc_a, acc_b, lost, sb_err;
  int   free_slots;

  // Candidate selection: queue head first, then load, then ALU.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    out_ent  = '0;
    out_v    = 1'b0;
    push_a   = '0;
    push_a_v = 1'b0;
    push_b   = '0;
    push_b_v = 1'b0;

    ld_in  = '{addr: ld_addr, data: ld_data};
    alu_in = '{addr: alu_addr, data: alu_data};
    head   = q_mem[rd_ptr];
    ld_ok  = ld_valid && (ld_addr != '0);
    alu_ok = alu_valid && (alu_addr != '0);
    new0   = ld_ok ? ld_in : alu_in;
    new0_v = ld_ok || alu_ok;
    new1   = alu_in;
    new1_v = ld_ok && alu_ok;
    pop    = (count != '0);

    if (pop) begin
      out_ent  = head;
      out_v    = 1'b1;
      push_a   = new0;
      push_a_v = new0_v;
      push_b   = new1;
      push_b_v = new1_v;
    end else begin
      out_ent  = new0;
      out_v    = new0_v;
      push_a   = new1;
      push_a_v = new1_v;
    end

    // The pop frees a slot in the same cycle, so a full queue still takes one push.
    free_slots = QDEPTH - int'(count) + int'(pop);
    acc_a      = push_a_v && (free_slots >= 1);
    acc_b      = push_b_v && (free_slots >= 2);
    lost       = (push_a_v && !acc_a) || (push_b_v && !acc_b);
  end

  always_comb begin
    busy   = '0;
    sb_err = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (sb[r] != 2'd0);
      if (iss_valid && iss_addr == RSIZE'(r) && !(Wen && WAddr == RSIZE'(r)) && sb[r] == 2'd3)
        sb_err = 1'b1;
      if (Wen && WAddr == RSIZE'(r) && !(iss_valid && iss_addr == RSIZE'(r)) && sb[r] == 2'd0)
        sb_err = 1'b1;
    end
  end

  assign wb_stall = (count >= CW'(QDEPTH - 1));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Wen      <= 1'b0;
      WAddr    <= '0;
      WData    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      Wen <= out_v;
      if (out_v) begin
        WAddr <= out_ent.addr;
        WData <= out_ent.data;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= wr_ptr + PW'(acc_a) + PW'(acc_b);
      count  <= count - CW'(pop) + CW'(acc_a) + CW'(acc_b);
      if (lost || sb_err)
        overflow <= 1'b1;
    end
  end

  // NOTE: queue storage is not reset; count and pointers alone define which entries are live.
  always_ff @(posedge Clock) begin
    if (acc_a)
      q_mem[wr_ptr] <= push_a;
    if (acc_b)
      q_mem[wr_ptr + PW'(1)] <= push_b;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int r = 1; r < NREG; r++)
        sb[r] <= 2'd0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (iss_valid && iss_addr == RSIZE'(r) && !(Wen && WAddr == RSIZE'(r))) begin
          if (sb[r] != 2'd3)
            sb[r] <= sb[r] + 2'd1;
        end else if (Wen && WAddr == RSIZE'(r) && !(iss_valid && iss_addr == RSIZE'(r))) begin
          if (sb[r] != 2'd0)
            sb[r] <= sb[r] - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl: reset, single write, collision,
// back-pressure, R0 drop, same-edge scoreboard, overflow and mid-run reset.
module tb_rf_writeback_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        alu_valid, ld_valid, iss_valid;
  logic [3:0]  alu_addr, ld_addr, iss_addr;
  logic [15:0] alu_data, ld_data;
  logic        Wen, wb_stall, overflow;
  logic [3:0]  WAddr;
  logic [15:0] WData;
  logic [15:0] busy;

  int checks = 0;
  int errors = 0;

  rf_writeback_ctrl #(.DSIZE(16), .RSIZE(4), .QDEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .Wen(Wen), .WAddr(WAddr), .WData(WData),
    .busy(busy), .wb_stall(wb_stall), .overflow(overflow)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
    iss_valid = 1'b0; iss_addr = '0;
  endtask

  task automatic issue(input logic [3:0] r);
    iss_valid = 1'b1;
    iss_addr  = r;
    tick();
    iss_valid = 1'b0;
  endtask

  logic [3:0]  ov_addr [10];
  logic [15:0] ov_data [10];

  initial begin
    ov_addr = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd4, 4'd12, 4'd5, 4'd6};
    ov_data = '{16'hC000, 16'hD000, 16'hC001, 16'hD001, 16'hC002,
                16'hD002, 16'hC003, 16'hD003, 16'hC004, 16'hC005};

    // Reset then idle
    idle();
    Reset = 1'b0;
    tick();
    tick();
    check("rst_wen", Wen, 0);
    check("rst_waddr", WAddr, 0);
    check("rst_wdata", WData, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", wb_stall, 0);
    check("rst_ovf", overflow, 0);
    Reset = 1'b1;
    tick();
    check("idle_wen", Wen, 0);
    check("idle_busy", busy, 0);

    // Single ALU write to R3
    issue(4'd3);
    check("single_busy_after_iss", busy[3], 1);
    tick();
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
    tick();
    idle();
    check("single_wen", Wen, 1);
    check("single_waddr", WAddr, 3);
    check("single_wdata", WData, 16'h1234);
    check("single_busy_wen_cycle", busy[3], 1);
    tick();
    check("single_wen_drop", Wen, 0);
    check("single_busy_clear", busy[3], 0);
    check("single_waddr_hold", WAddr, 3);
    check("single_wdata_hold", WData, 16'h1234);

    // Collision: load wins over ALU in the same cycle
    issue(4'd5);
    issue(4'd6);
    ld_valid  = 1'b1; ld_addr  = 4'd5; ld_data  = 16'hAAAA;
    alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 16'h5555;
    tick();
    idle();
    check("coll_wen0", Wen, 1);
    check("coll_addr0", WAddr, 5);
    check("coll_data0", WData, 16'hAAAA);
    tick();
    check("coll_wen1", Wen, 1);
    check("coll_addr1", WAddr, 6);
    check("coll_data1", WData, 16'h5555);
    tick();
    check("coll_wen_done", Wen, 0);
    check("coll_busy", busy, 0);
    check("coll_ovf", overflow, 0);

    // Back-pressure: four cycles of dual input, then drain
    for (int r = 1; r <= 8; r++) issue(4'(r));
    check("bp_busy_issued", busy, 16'h01FE);
    for (int k = 0; k < 4; k++) begin
      ld_valid  = 1'b1; ld_addr  = 4'(2 * k + 1); ld_data  = 16'hA000 + 16'(k);
      alu_valid = 1'b1; alu_addr = 4'(2 * k + 2); alu_data = 16'hB000 + 16'(k);
      tick();
      check("bp_wen", Wen, 1);
      check("bp_addr", WAddr, k + 1);
      check("bp_data", WData, (k % 2 == 0) ? 16'hA000 + 16'(k / 2) : 16'hB000 + 16'(k / 2));
      check("bp_stall", wb_stall, (k >= 2) ? 1 : 0);
    end
    idle();
    for (int i = 4; i < 8; i++) begin
      tick();
      check("bp_drain_wen", Wen, 1);
      check("bp_drain_addr", WAddr, i + 1);
      check("bp_drain_data", WData, (i % 2 == 0) ? 16'hA000 + 16'(i / 2) : 16'hB000 + 16'(i / 2));
      check("bp_drain_stall", wb_stall, (i == 4) ? 1 : 0);
    end
    tick();
    check("bp_done_wen", Wen, 0);
    check("bp_busy", busy, 0);
    check("bp_ovf", overflow, 0);

    // R0 writes are dropped
    alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 16'hFFFF;
    tick();
    idle();
    check("r0_wen", Wen, 0);
    tick();
    check("r0_wen_late", Wen, 0);

    // Issue on the same edge as the RF write keeps the counter at 1
    issue(4'd7);
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 16'h7777;
    tick();
    idle();
    check("same_wen", Wen, 1);
    check("same_addr", WAddr, 7);
    iss_valid = 1'b1; iss_addr = 4'd7;
    tick();
    idle();
    check("same_busy_held", busy[7], 1);
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 16'h7778;
    tick();
    idle();
    check("same_wen2", Wen, 1);
    check("same_data2", WData, 16'h7778);
    tick();
    check("same_busy_clear", busy[7], 0);
    check("same_ovf", overflow, 0);

    // Overflow: ignore wb_stall for six cycles; ALU inputs get dropped
    for (int r = 1; r <= 6; r++) issue(4'(r));
    for (int r = 9; r <= 14; r++) issue(4'(r));
    for (int k = 0; k < 6; k++) begin
      ld_valid  = 1'b1; ld_addr  = 4'(k + 1); ld_data  = 16'hC000 + 16'(k);
      alu_valid = 1'b1; alu_addr = 4'(k + 9); alu_data = 16'hD000 + 16'(k);
      tick();
      check("ov_wen", Wen, 1);
      check("ov_addr", WAddr, ov_addr[k]);
      check("ov_data", WData, ov_data[k]);
      check("ov_flag", overflow, (k >= 4) ? 1 : 0);
    end
    idle();
    for (int i = 6; i < 10; i++) begin
      tick();
      check("ov_drain_wen", Wen, 1);
      check("ov_drain_addr", WAddr, ov_addr[i]);
      check("ov_drain_data", WData, ov_data[i]);
    end
    tick();
    check("ov_done_wen", Wen, 0);
    check("ov_busy_dropped", busy, 16'h6000);
    check("ov_sticky", overflow, 1);

    // Reset mid-operation discards queued writes
    ld_valid  = 1'b1; ld_addr  = 4'd1; ld_data  = 16'h1111;
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'h2222;
    tick();
    tick();
    idle();
    Reset = 1'b0;
    tick();
    check("mid_rst_wen", Wen, 0);
    check("mid_rst_waddr", WAddr, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stall", wb_stall, 0);
    Reset = 1'b1;
    tick();
    check("post_rst_wen0", Wen, 0);
    tick();
    check("post_rst_wen1", Wen, 0);
    check("post_rst_ovf", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Write-side controller for the 16-entry register file. It merges the two writeback producers, the single-cycle ALU path and the multi-cycle load return path, into the one RF write port (Wen/WAddr/WData).
- Holds a small in-order queue for collisions.
- Keeps a per-register pending-write scoreboard that the decode stage uses for RAW hazard stalls.
- Sits between the EX/MEM writeback sources and the register file write port.

Parameters:
DSIZE, 16, data width
RSIZE, 4, register address width (2^RSIZE registers)
QDEPTH, 4, writeback queue depth (power of 2, >=2)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
alu_valid  in  1  ALU result valid this cycle
alu_addr  in  RSIZE  ALU destination register
alu_data  in  DSIZE  ALU result
ld_valid  in  1  load data returning this cycle
ld_addr  in  RSIZE  load destination register
ld_data  in  DSIZE  load data
iss_valid  in  1  decode issues an instruction with a register destination
iss_addr  in  RSIZE  destination of issued instruction
Wen  out  1  RF write enable (registered)
WAddr  out  RSIZE  RF write address (registered)
WData  out  DSIZE  RF write data (registered)
busy  out  2^RSIZE  bit r = 1 while register r has an outstanding write
wb_stall  out  1  upstream must hold new producers (queue nearly full)
overflow  out  1  sticky error: an input was lost

Behaviour:
- Reset (Reset==0 at a rising edge):
  - Wen=0, WAddr=0, WData=0.
  - Queue emptied, count=0.
  - All scoreboard counters = 0, so busy=0.
  - overflow=0.
  - Reset mid-operation discards queued writes with no RF write issued.
- Dropped inputs: inputs with addr==0 are ignored for both queueing and scoreboard (R0 hardwired).
- Candidate order each cycle: existing queue entries (oldest first), then ld input, then alu input. The load is program-older than the ALU op completing in the same cycle.
- Pop/push each cycle: at each rising edge the oldest candidate drives the outputs (Wen<=1, WAddr/WData<=its fields). Remaining new candidates are pushed into the queue in the order above. With no candidate, Wen<=0; WAddr/WData hold their value.
- Latency: an input arriving with the queue empty appears on Wen/WAddr/WData the following cycle. The RF writes it at the edge after that, and the RF read bypass covers the Wen cycle.
- Throughput: exactly 1 write per cycle. Net queue growth is at most +1 per cycle (2 in, 1 out).
- wb_stall = (count >= QDEPTH-1), combinational from the registered count.
- Overflow: if a push would exceed QDEPTH, the excess youngest input (alu first) is dropped and overflow is set, staying set until reset. Queue contents and order are otherwise unaffected.
- Scoreboard: one 2-bit counter per register r (r=1..2^RSIZE-1).
  - +1 at an edge where iss_valid && iss_addr==r.
  - -1 at an edge where Wen && WAddr==r (the RF write edge).
  - Both at the same edge leaves the counter unchanged.
  - Increment at 3 saturates and sets overflow; decrement at 0 stays 0 and sets overflow.
  - busy[r] = (counter!=0); busy[0]=0 always.
- Queue pointers wrap modulo QDEPTH. Full and empty are distinguished by count, not by pointer equality.

Test Plan:
- Reset then idle: hold Reset=0 2 cycles, release -> Wen=0, WAddr=0, WData=0, busy=0, wb_stall=0, overflow=0.
- Single ALU write: iss R3 at cycle 0; alu_valid R3=16'h1234 at cycle 2 -> Wen=1, WAddr=3, WData=1234 in cycle 3; busy[3]=1 through cycle 3, 0 from cycle 4.
- Collision: ld R5=16'hAAAA and alu R6=16'h5555 in the same cycle, queue empty -> next cycle writes R5/AAAA, the cycle after writes R6/5555; no overflow.
- Back-pressure: alu+ld valid every cycle for 4 cycles with QDEPTH=4 -> wb_stall rises when count reaches 3; inputs stop on stall; all 8 writes emerge in order; no overflow.
- Overflow: ignore wb_stall and drive both inputs for 6 cycles -> overflow=1 when the queue is full; the dropped entries are always the ALU inputs; accepted writes drain in order.
- R0 and same-edge scoreboard: alu write to R0 -> no Wen. Issue R7 on the same edge Wen commits R7 while its counter=1 -> counter stays 1, busy[7] stays 1.
